// File: rtl/usb_reg_fe_pkg.sv
// Shared types and constants for the wide USB register frontend.
package usb_reg_fe_pkg;

    // Read-side controller states.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_t;

    // Byte returned for every lane of a read that timed out.
    localparam logic [7:0] ABORT_BYTE = 8'hEE;

    // Number of address bits that select a byte lane inside a register word.
    function automatic int lane_bits(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/usb_reg_fe_wide_strobe_sync.sv
// Registers one active-low host strobe together with chip enable and
// produces a single-cycle pulse on the qualified falling edge.
module usb_strobe_sync (
    input  logic usb_clk,
    input  logic rst,
    input  logic strobe_n,
    input  logic cen_n,
    output logic strobe_n_r,
    output logic event_pulse
);

    logic strobe_n_rr;
    logic cen_n_r;

    // Two-stage strobe history plus one stage of chip enable; idle level is high.
    always_ff @(posedge usb_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the pre-edge
        // value, so strobe_n_rr really is one cycle older than strobe_n_r.
        if (rst) begin
            strobe_n_r  <= 1'b1;
            strobe_n_rr <= 1'b1;
            cen_n_r     <= 1'b1;
        end else begin
            strobe_n_r  <= strobe_n;
            strobe_n_rr <= strobe_n_r;
            cen_n_r     <= cen_n;
        end
    end

    // One pulse per strobe, however long the host holds it low.
    assign event_pulse = ~cen_n_r & ~strobe_n_r & strobe_n_rr;

endmodule

// File: rtl/usb_reg_fe_wide.sv
// Wide USB register frontend: assembles byte-serial host writes into
// register words with byte strobes, and serves byte reads from a cached
// register word fetched over a req/ack handshake.
module usb_reg_fe_wide
    import usb_reg_fe_pkg::*;
#(
    parameter int pADDR_WIDTH    = 21,
    parameter int pBYTECNT_SIZE  = 7,
    parameter int pWORD_BYTES    = 4,
    parameter int pREG_RDDLY_LEN = 3,
    parameter int pRD_TIMEOUT    = 255
) (
    input  logic                                                usb_clk,
    input  logic                                                rst,
    input  logic [7:0]                                          usb_din,
    output logic [7:0]                                          usb_dout,
    output logic                                                usb_isout,
    input  logic [pADDR_WIDTH-1:0]                              usb_addr,
    input  logic                                                usb_rdn,
    input  logic                                                usb_wrn,
    input  logic                                                usb_cen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]                reg_address,
    output logic [pBYTECNT_SIZE-$clog2(pWORD_BYTES)-1:0]        reg_word_idx,
    output logic [8*pWORD_BYTES-1:0]                            reg_wdata,
    output logic [pWORD_BYTES-1:0]                              reg_wstrb,
    output logic                                                reg_write,
    output logic                                                reg_rd_req,
    input  logic                                                reg_rd_ack,
    input  logic [8*pWORD_BYTES-1:0]                            reg_rdata,
    output logic                                                err_abort
);

    localparam int LANE_BITS = lane_bits(pWORD_BYTES);
    localparam int LW        = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int IDX_W     = pBYTECNT_SIZE - LANE_BITS;
    localparam int KEY_W     = pADDR_WIDTH - LANE_BITS;
    localparam int TCNT_W    = $clog2(pRD_TIMEOUT + 1);
    localparam logic [LW-1:0]     LAST_LANE = LW'(pWORD_BYTES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(pRD_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Host input stage
    // ------------------------------------------------------------------
    logic [pADDR_WIDTH-1:0] addr_r;
    logic [7:0]             din_r;
    logic                   rdn_r;
    logic                   unused_wrn_r;
    logic                   wr_ev;
    logic                   rd_ev;

    // Address and write data registered once, aligned with the strobe events.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            addr_r <= '0;
            din_r  <= '0;
        end else begin
            addr_r <= usb_addr;
            din_r  <= usb_din;
        end
    end

    usb_strobe_sync u_wr_sync (
        .usb_clk     (usb_clk),
        .rst         (rst),
        .strobe_n    (usb_wrn),
        .cen_n       (usb_cen),
        .strobe_n_r  (unused_wrn_r),
        .event_pulse (wr_ev)
    );

    usb_strobe_sync u_rd_sync (
        .usb_clk     (usb_clk),
        .rst         (rst),
        .strobe_n    (usb_rdn),
        .cen_n       (usb_cen),
        .strobe_n_r  (rdn_r),
        .event_pulse (rd_ev)
    );

    // Lane selects the byte inside a word; key identifies the word itself.
    logic [LW-1:0]          lane;
    logic [KEY_W-1:0]       key;
    logic [pWORD_BYTES-1:0] lane_onehot;

    assign lane        = (LANE_BITS > 0) ? addr_r[LW-1:0] : '0;
    assign key         = addr_r[pADDR_WIDTH-1:LANE_BITS];
    assign lane_onehot = pWORD_BYTES'(1) << lane;

    // ------------------------------------------------------------------
    // Write assembly
    // ------------------------------------------------------------------
    logic [pWORD_BYTES-1:0][7:0] shadow;
    logic [pWORD_BYTES-1:0][7:0] shadow_new;
    logic [pWORD_BYTES-1:0]      wstrb_acc;
    logic [KEY_W-1:0]            wkey;
    logic [KEY_W-1:0]            commit_key;
    logic                        pend_commit;
    logic                        key_switch;
    logic                        commit_now;

    // Shadow word with the incoming byte merged into its lane.
    always_comb begin
        // NOTE: full default first so no path through this block leaves a bit
        // unassigned, which would otherwise infer a latch.
        shadow_new       = shadow;
        shadow_new[lane] = din_r;
    end

    // A pending partial word is flushed when the host moves to another word.
    assign key_switch = wr_ev & (|wstrb_acc) & (key != wkey);

    // Edge at which reg_write will be raised; the read cache goes stale here.
    assign commit_now = pend_commit | (wr_ev & (key_switch | (lane == LAST_LANE)));

    // Byte accumulation, strobe tracking and commit pulse generation.
    always_ff @(posedge usb_clk) begin
        // NOTE: the shadow word is only a handful of flops, so it is reset too;
        // partial commits then never expose undefined bytes in unwritten lanes.
        if (rst) begin
            shadow      <= '0;
            wstrb_acc   <= '0;
            wkey        <= '0;
            pend_commit <= 1'b0;
            reg_write   <= 1'b0;
            reg_wdata   <= '0;
            reg_wstrb   <= '0;
            commit_key  <= '0;
        end else begin
            reg_write   <= 1'b0;
            pend_commit <= 1'b0;
            if (pend_commit) begin
                // Deferred commit of a new word whose first byte completed it.
                // Strobe events are at least two cycles apart, so no event
                // can coincide with this slot.
                reg_write  <= 1'b1;
                reg_wdata  <= shadow;
                reg_wstrb  <= wstrb_acc;
                commit_key <= wkey;
                wstrb_acc  <= '0;
            end else if (wr_ev) begin
                shadow <= shadow_new;
                wkey   <= key;
                if (key_switch) begin
                    // Old partial word goes out now; the new byte starts the next word.
                    reg_write   <= 1'b1;
                    reg_wdata   <= shadow;
                    reg_wstrb   <= wstrb_acc;
                    commit_key  <= wkey;
                    wstrb_acc   <= lane_onehot;
                    pend_commit <= (lane == LAST_LANE);
                end else if (lane == LAST_LANE) begin
                    reg_write  <= 1'b1;
                    reg_wdata  <= shadow_new;
                    reg_wstrb  <= wstrb_acc | lane_onehot;
                    commit_key <= key;
                    wstrb_acc  <= '0;
                end else begin
                    wstrb_acc <= wstrb_acc | lane_onehot;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read controller
    // ------------------------------------------------------------------
    rd_state_t                   state;
    rd_state_t                   state_nxt;
    logic                        rd_start;
    logic                        rd_done;
    logic                        rd_abort;
    logic                        rd_miss;
    logic [TCNT_W-1:0]           tcnt;
    logic [KEY_W-1:0]            rd_key;
    logic [pWORD_BYTES-1:0][7:0] cache_data;
    logic [KEY_W-1:0]            cache_key;
    logic                        cache_valid;
    logic [pREG_RDDLY_LEN-1:0]   isoutreg;

    // Lane 0 always refetches so a fresh multi-byte read sees current data.
    assign rd_miss = (lane == '0) | ~cache_valid | (key != cache_key);

    // State register.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt = state;
        rd_start  = 1'b0;
        rd_done   = 1'b0;
        rd_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_ev && rd_miss) begin
                    rd_start  = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (reg_rd_ack) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (tcnt == TCNT_LAST) begin
                    rd_abort  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request key, timeout counter, cache fill and host read data.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            tcnt        <= '0;
            rd_key      <= '0;
            cache_data  <= '0;
            cache_key   <= '0;
            cache_valid <= 1'b0;
            err_abort   <= 1'b0;
            usb_dout    <= '0;
            isoutreg    <= '0;
        end else begin
            err_abort <= rd_abort;

            if (rd_start) begin
                rd_key <= key;
                tcnt   <= '0;
            end else if (state == RD_WAIT) begin
                tcnt <= (rd_done | rd_abort) ? '0 : tcnt + 1'b1;
            end

            if (rd_done) begin
                cache_data <= reg_rdata;
                cache_key  <= rd_key;
            end else if (rd_abort) begin
                cache_data <= {pWORD_BYTES{ABORT_BYTE}};
                cache_key  <= rd_key;
            end

            // A commit on the same edge wins: the fetched word may be stale.
            if (commit_now) begin
                cache_valid <= 1'b0;
            end else if (rd_done | rd_abort) begin
                cache_valid <= 1'b1;
            end

            usb_dout <= cache_data[lane];
            isoutreg <= {isoutreg[pREG_RDDLY_LEN-2:0], ~rdn_r};
        end
    end

    // Bus turnaround: keep driving for a few cycles after the read strobe.
    assign usb_isout = ~rdn_r | (|isoutreg);

    assign reg_rd_req = (state == RD_WAIT);

    // The register select follows the commit during a write pulse and the
    // outstanding read otherwise.
    logic [KEY_W-1:0] sel_key;
    assign sel_key      = reg_write ? commit_key : rd_key;
    assign reg_address  = sel_key[KEY_W-1:IDX_W];
    assign reg_word_idx = sel_key[IDX_W-1:0];

endmodule

// File: tb/tb_usb_reg_fe_wide.sv
// Directed, self-checking bench for usb_reg_fe_wide with default parameters.
module tb_usb_reg_fe_wide;

    logic        usb_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  usb_din = '0;
    logic [7:0]  usb_dout;
    logic        usb_isout;
    logic [20:0] usb_addr = '0;
    logic        usb_rdn = 1'b1;
    logic        usb_wrn = 1'b1;
    logic        usb_cen = 1'b1;
    logic [13:0] reg_address;
    logic [4:0]  reg_word_idx;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_write;
    logic        reg_rd_req;
    logic        reg_rd_ack = 1'b0;
    logic [31:0] reg_rdata = '0;
    logic        err_abort;

    usb_reg_fe_wide dut (
        .usb_clk      (usb_clk),
        .rst          (rst),
        .usb_din      (usb_din),
        .usb_dout     (usb_dout),
        .usb_isout    (usb_isout),
        .usb_addr     (usb_addr),
        .usb_rdn      (usb_rdn),
        .usb_wrn      (usb_wrn),
        .usb_cen      (usb_cen),
        .reg_address  (reg_address),
        .reg_word_idx (reg_word_idx),
        .reg_wdata    (reg_wdata),
        .reg_wstrb    (reg_wstrb),
        .reg_write    (reg_write),
        .reg_rd_req   (reg_rd_req),
        .reg_rd_ack   (reg_rd_ack),
        .reg_rdata    (reg_rdata),
        .err_abort    (err_abort)
    );

    always #5 usb_clk = ~usb_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- commit / request monitor ----------------
    typedef struct {
        logic [13:0] rg;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } commit_t;

    commit_t commits[$];
    int      req_hi_cnt = 0;
    int      req_rise   = 0;
    int      abort_cnt  = 0;
    bit      req_prev   = 1'b0;

    always @(negedge usb_clk) begin
        commit_t c;
        if (reg_write) begin
            c.rg    = reg_address;
            c.idx   = reg_word_idx;
            c.wdata = reg_wdata;
            c.wstrb = reg_wstrb;
            commits.push_back(c);
        end
        if (reg_rd_req) req_hi_cnt++;
        if (reg_rd_req && !req_prev) req_rise++;
        req_prev = reg_rd_req;
        if (err_abort) abort_cnt++;
    end

    // ---------------- register-file responder ----------------
    bit          ack_mode  = 1'b1;
    int          ack_delay = 10;
    logic [31:0] resp_data = '0;
    logic [13:0] ack_reg   = '0;
    logic [4:0]  ack_idx   = '0;

    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge usb_clk);
            reg_rd_ack = 1'b0;
            if (reg_rd_req && ack_mode) begin
                wait_cnt++;
                if (wait_cnt == ack_delay) begin
                    reg_rd_ack = 1'b1;
                    reg_rdata  = resp_data;
                    ack_reg    = reg_address;
                    ack_idx    = reg_word_idx;
                    wait_cnt   = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- host bus tasks ----------------
    task automatic host_write(input logic [13:0] rg, input logic [6:0] bc, input logic [7:0] d);
        @(negedge usb_clk);
        usb_addr = {rg, bc};
        usb_din  = d;
        usb_cen  = 1'b0;
        usb_wrn  = 1'b0;
        repeat (2) @(negedge usb_clk);
        usb_wrn = 1'b1;
        usb_cen = 1'b1;
        repeat (2) @(negedge usb_clk);
    endtask

    task automatic host_read(input logic [13:0] rg, input logic [6:0] bc);
        @(negedge usb_clk);
        usb_addr = {rg, bc};
        usb_cen  = 1'b0;
        usb_rdn  = 1'b0;
        repeat (2) @(negedge usb_clk);
        usb_rdn = 1'b1;
        usb_cen = 1'b1;
        repeat (2) @(negedge usb_clk);
    endtask

    // Wait (bounded) for the outstanding request to be released.
    task automatic wait_req_drop(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge usb_clk);
            if (!reg_rd_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    // ---------------- write vector table ----------------
    typedef struct {
        logic [13:0] rg;
        logic [6:0]  bc;
        logic [7:0]  din;
        bit          exp_commit;
        logic [13:0] exp_rg;
        logic [4:0]  exp_idx;
        logic [31:0] exp_wdata;   // compared under exp_wstrb only
        logic [3:0]  exp_wstrb;
    } wvec_t;

    wvec_t wv[13];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        bit          ok;
        logic [7:0]  iso;

        //              rg     bc     din    c  exp_rg exp_idx exp_wdata      exp_wstrb
        wv[0]  = '{14'd5, 7'd0, 8'h11, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[1]  = '{14'd5, 7'd1, 8'h22, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[2]  = '{14'd5, 7'd2, 8'h33, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[3]  = '{14'd5, 7'd3, 8'h44, 1, 14'd5, 5'd0, 32'h44332211,  4'hF};
        wv[4]  = '{14'd5, 7'd0, 8'hAA, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[5]  = '{14'd5, 7'd1, 8'hBB, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[6]  = '{14'd6, 7'd0, 8'hCC, 1, 14'd5, 5'd0, 32'h0000BBAA,  4'h3};
        wv[7]  = '{14'd6, 7'd2, 8'hDD, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[8]  = '{14'd6, 7'd1, 8'hEE, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[9]  = '{14'd6, 7'd2, 8'hD0, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[10] = '{14'd6, 7'd3, 8'hFF, 1, 14'd6, 5'd0, 32'hFFD0EECC,  4'hF};
        wv[11] = '{14'd6, 7'd5, 8'h55, 0, 14'd0, 5'd0, 32'h0,         4'h0};
        wv[12] = '{14'd6, 7'd7, 8'h77, 1, 14'd6, 5'd1, 32'h77005500,  4'hA};

        // ---- reset state ----
        repeat (3) @(negedge usb_clk);
        check("reset_ctrl", {usb_dout, usb_isout, reg_address, reg_word_idx,
                             reg_wstrb, reg_write, reg_rd_req, err_abort}, '0);
        check("reset_wdata", reg_wdata, '0);
        rst = 1'b0;
        repeat (2) @(negedge usb_clk);

        // ---- table-driven write assembly ----
        for (int i = 0; i < 13; i++) begin
            commits.delete();
            host_write(wv[i].rg, wv[i].bc, wv[i].din);
            check($sformatf("wr%0d_commits", i), commits.size(), wv[i].exp_commit ? 1 : 0);
            if (wv[i].exp_commit && commits.size() > 0) begin
                check($sformatf("wr%0d_reg", i), commits[0].rg, wv[i].exp_rg);
                check($sformatf("wr%0d_idx", i), commits[0].idx, wv[i].exp_idx);
                check($sformatf("wr%0d_wstrb", i), commits[0].wstrb, wv[i].exp_wstrb);
                check($sformatf("wr%0d_wdata", i),
                      commits[0].wdata & strb_mask(wv[i].exp_wstrb), wv[i].exp_wdata);
            end
        end

        // ---- key switch where the new byte also completes its word ----
        commits.delete();
        host_write(14'd8, 7'd0, 8'h01);
        host_write(14'd9, 7'd3, 8'h99);
        check("ksw_commits", commits.size(), 2);
        if (commits.size() == 2) begin
            check("ksw_old", {commits[0].rg, commits[0].wstrb, commits[0].wdata[7:0]},
                  {14'd8, 4'h1, 8'h01});
            check("ksw_new", {commits[1].rg, commits[1].wstrb, commits[1].wdata[31:24]},
                  {14'd9, 4'h8, 8'h99});
        end

        // ---- atomic multi-byte read of reg 7 ----
        ack_mode  = 1'b1;
        ack_delay = 10;
        resp_data = 32'hA1B2C3D4;
        host_read(14'd7, 7'd0);
        wait_req_drop(50, ok);
        check("rd0_acked", ok, 1'b1);
        check("rd0_req_key", {ack_reg, ack_idx}, {14'd7, 5'd0});
        @(negedge usb_clk);
        check("rd0_dout", usb_dout, 8'hD4);
        host_read(14'd7, 7'd1);
        check("rd1_dout", usb_dout, 8'hC3);

        // bc2 driven by hand to observe the bus-drive window
        repeat (4) @(negedge usb_clk);
        usb_addr = {14'd7, 7'd2};
        usb_cen  = 1'b0;
        usb_rdn  = 1'b0;
        iso[0]   = usb_isout;
        for (int i = 1; i < 8; i++) begin
            @(negedge usb_clk);
            iso[i] = usb_isout;
            if (i == 2) begin
                usb_rdn = 1'b1;
                usb_cen = 1'b1;
            end
            if (i == 4) check("rd2_dout", usb_dout, 8'hB2);
        end
        check("isout_window", iso, 8'b0011_1110);
        host_read(14'd7, 7'd3);
        check("rd3_dout", usb_dout, 8'hA1);
        check("rd_single_req", req_rise, 1);

        // ---- commit invalidates cache ----
        resp_data = 32'h01020304;
        ack_delay = 4;
        host_read(14'd7, 7'd0);
        wait_req_drop(50, ok);
        @(negedge usb_clk);
        check("inv_first_dout", usb_dout, 8'h04);
        commits.delete();
        host_write(14'd7, 7'd3, 8'h5A);
        check("inv_commit", commits.size() == 1 ? {commits[0].rg, commits[0].wstrb} : 18'h0,
              {14'd7, 4'h8});
        resp_data = 32'h11223344;
        host_read(14'd7, 7'd1);
        wait_req_drop(50, ok);
        @(negedge usb_clk);
        check("inv_req_count", req_rise, 3);
        check("inv_dout", usb_dout, 8'h33);

        // ---- read timeout ----
        ack_mode   = 1'b0;
        req_hi_cnt = 0;
        abort_cnt  = 0;
        host_read(14'd7, 7'd0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge usb_clk);
            if (err_abort) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_abort_seen", ok, 1'b1);
        check("to_req_cycles", req_hi_cnt, 255);
        check("to_req_dropped", reg_rd_req, 1'b0);
        @(negedge usb_clk);
        check("to_pulse_once", {err_abort, 32'(abort_cnt)}, {1'b0, 32'd1});
        check("to_dout", usb_dout, 8'hEE);
        ack_mode  = 1'b1;
        ack_delay = 3;
        resp_data = 32'hCAFEF00D;
        host_read(14'd7, 7'd0);
        wait_req_drop(50, ok);
        @(negedge usb_clk);
        check("to_fresh_req", req_rise, 5);
        check("to_fresh_dout", usb_dout, 8'h0D);

        // ---- reset during RD_WAIT with a partial write pending ----
        ack_mode = 1'b0;
        host_write(14'd10, 7'd0, 8'h12);
        host_read(14'd10, 7'd0);
        check("rst_pre_req", reg_rd_req, 1'b1);
        commits.delete();
        abort_cnt = 0;
        rst = 1'b1;
        @(negedge usb_clk);
        check("rst_mid_ctrl", {usb_dout, usb_isout, reg_address, reg_word_idx,
                               reg_wstrb, reg_write, reg_rd_req, err_abort}, '0);
        check("rst_mid_wdata", reg_wdata, '0);
        @(negedge usb_clk);
        rst = 1'b0;
        repeat (5) @(negedge usb_clk);
        check("rst_no_side_effects", {32'(commits.size()), 32'(abort_cnt)}, 64'h0);
        host_write(14'd10, 7'd3, 8'h34);
        check("rst_acc_cleared", commits.size() == 1 ? {commits[0].rg, commits[0].wstrb} : 18'h0,
              {14'd10, 4'h8});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
